// File: rtl/pipeline_sequencer.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, multi-cycle MUL
// occupancy of EX, branch/jump redirect flushes and the HALT/resume handshake.
module pipeline_sequencer #(
  parameter int          REG_AW       = 3,
  parameter int          MUL_CYCLES   = 3,
  parameter int          LOAD_BUBBLES = 1,
  parameter int          CNT_W        = 16,
  parameter logic [4:0]  OP_MUL       = 5'h06,
  parameter logic [4:0]  OP_HALT      = 5'h1F
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [4:0]        id_opcode,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_uses_rs2,
  input  logic              ex_mem_read,
  input  logic              ex_reg_write,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_redirect,
  input  logic              resume,
  output logic              pc_en,
  output logic              if_id_en,
  output logic              if_id_flush,
  output logic              id_ex_en,
  output logic              id_ex_flush,
  output logic              ex_hold,
  output logic              halted,
  output logic [CNT_W-1:0]  stall_cycles
);

  localparam int CNT_MAX = (MUL_CYCLES > LOAD_BUBBLES) ? MUL_CYCLES : LOAD_BUBBLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {RUN, LOAD_STALL, MUL_WAIT, HALT} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             lu;

  assign lu = id_valid & ex_mem_read & ex_reg_write &
              ((ex_rd == id_rs1) | (id_uses_rs2 & (ex_rd == id_rs2)));

  always_comb begin
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    if_id_flush = 1'b0;
    id_ex_en    = 1'b1;
    id_ex_flush = 1'b0;
    ex_hold     = 1'b0;
    halted      = 1'b0;
    state_d     = state_q;
    cnt_d       = cnt_q;
    case (state_q)
      RUN: begin
        if (ex_redirect) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (lu) begin
          pc_en       = 1'b0;
          if_id_en    = 1'b0;
          id_ex_flush = 1'b1;
          if (LOAD_BUBBLES > 1) begin
            state_d = LOAD_STALL;
            cnt_d   = CW'(LOAD_BUBBLES - 1);
          end
        end else if (id_valid && id_opcode == OP_MUL) begin
          if (MUL_CYCLES > 1) begin
            state_d = MUL_WAIT;
            cnt_d   = CW'(MUL_CYCLES - 1);
          end
        end else if (id_valid && id_opcode == OP_HALT) begin
          state_d = HALT;
        end
      end
      LOAD_STALL: begin
        // A redirect squashes the dependent instruction, so the remaining bubbles are moot.
        if (ex_redirect) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          state_d     = RUN;
          cnt_d       = '0;
        end else begin
          pc_en       = 1'b0;
          if_id_en    = 1'b0;
          id_ex_flush = 1'b1;
          cnt_d       = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = RUN;
        end
      end
      MUL_WAIT: begin
        pc_en    = 1'b0;
        if_id_en = 1'b0;
        id_ex_en = 1'b0;
        ex_hold  = 1'b1;
        cnt_d    = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = RUN;
      end
      HALT: begin
        halted      = 1'b1;
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_flush = 1'b1;
        if (resume) begin
          halted      = 1'b0;
          if_id_flush = 1'b1;
          pc_en       = 1'b1;
          state_d     = RUN;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
    stall_d = (!pc_en && stall_q != {CNT_W{1'b1}}) ? stall_q + CNT_W'(1) : stall_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
    end
  end

  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed bench for pipeline_sequencer: default build, a LOAD_BUBBLES=2 build and a
// CNT_W=4 build share one stimulus stream; expected outputs go through a scoreboard queue.
module tb_pipeline_sequencer;

  localparam logic [4:0] OP_ADD  = 5'h01;
  localparam logic [4:0] OP_MUL  = 5'h06;
  localparam logic [4:0] OP_HALT = 5'h1F;

  // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_hold, halted}
  localparam logic [6:0] DEF = 7'b1101000;
  localparam logic [6:0] LU  = 7'b0001100;
  localparam logic [6:0] RD  = 7'b1111100;
  localparam logic [6:0] MW  = 7'b0000010;
  localparam logic [6:0] HO  = 7'b0001101;
  localparam logic [6:0] RS  = 7'b1011100;
  localparam logic [6:0] ALL = 7'b1111111;
  localparam logic [6:0] RDM = 7'b1010100;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid, id_uses_rs2, ex_mem_read, ex_reg_write, ex_redirect, resume;
  logic [4:0] id_opcode;
  logic [2:0] id_rs1, id_rs2, ex_rd;

  logic        pc_m, ife_m, iff_m, ide_m, idf_m, hold_m, halt_m;
  logic        pc_l, ife_l, iff_l, ide_l, idf_l, hold_l, halt_l;
  logic        pc_s, ife_s, iff_s, ide_s, idf_s, hold_s, halt_s;
  logic [15:0] stall_m, stall_l;
  logic [3:0]  stall_s;
  logic [6:0]  o_m, o_l;

  assign o_m = {pc_m, ife_m, iff_m, ide_m, idf_m, hold_m, halt_m};
  assign o_l = {pc_l, ife_l, iff_l, ide_l, idf_l, hold_l, halt_l};

  always #5 clk = ~clk;

  pipeline_sequencer #(.REG_AW(3), .MUL_CYCLES(3), .LOAD_BUBBLES(1), .CNT_W(16),
                       .OP_MUL(OP_MUL), .OP_HALT(OP_HALT)) u_main (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
    .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write), .ex_rd(ex_rd),
    .ex_redirect(ex_redirect), .resume(resume),
    .pc_en(pc_m), .if_id_en(ife_m), .if_id_flush(iff_m), .id_ex_en(ide_m),
    .id_ex_flush(idf_m), .ex_hold(hold_m), .halted(halt_m), .stall_cycles(stall_m));

  pipeline_sequencer #(.REG_AW(3), .MUL_CYCLES(3), .LOAD_BUBBLES(2), .CNT_W(16),
                       .OP_MUL(OP_MUL), .OP_HALT(OP_HALT)) u_lb2 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
    .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write), .ex_rd(ex_rd),
    .ex_redirect(ex_redirect), .resume(resume),
    .pc_en(pc_l), .if_id_en(ife_l), .if_id_flush(iff_l), .id_ex_en(ide_l),
    .id_ex_flush(idf_l), .ex_hold(hold_l), .halted(halt_l), .stall_cycles(stall_l));

  pipeline_sequencer #(.REG_AW(3), .MUL_CYCLES(3), .LOAD_BUBBLES(1), .CNT_W(4),
                       .OP_MUL(OP_MUL), .OP_HALT(OP_HALT)) u_sat (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
    .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write), .ex_rd(ex_rd),
    .ex_redirect(ex_redirect), .resume(resume),
    .pc_en(pc_s), .if_id_en(ife_s), .if_id_flush(iff_s), .id_ex_en(ide_s),
    .id_ex_flush(idf_s), .ex_hold(hold_s), .halted(halt_s), .stall_cycles(stall_s));

  typedef struct {
    string      tag;
    logic [6:0] em;
    logic [6:0] el;
    logic [6:0] lmask;
  } exp_t;

  exp_t q[$];
  int   passed = 0;
  int   total  = 0;
  int   fails  = 0;
  int   exp_m  = 0;
  int   exp_l  = 0;
  int   exp_s  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) begin
      passed++;
    end else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] op, input logic [2:0] rs1,
                       input logic [2:0] rs2, input logic u2, input logic mr,
                       input logic rw, input logic [2:0] rd, input logic rdr,
                       input logic res);
    id_valid = v; id_opcode = op; id_rs1 = rs1; id_rs2 = rs2; id_uses_rs2 = u2;
    ex_mem_read = mr; ex_reg_write = rw; ex_rd = rd; ex_redirect = rdr; resume = res;
  endtask

  task automatic idle();
    drive(1'b0, OP_ADD, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd7, 1'b0, 1'b0);
  endtask

  // Inputs are already driven; queue the expectation, compare mid-cycle, then clock.
  task automatic cyc(input string tag, input logic [6:0] em, input logic [6:0] el,
                     input logic [6:0] lmask);
    exp_t e;
    q.push_back('{tag, em, el, lmask});
    #1;
    e = q.pop_front();
    chk({e.tag, "_main"}, 32'(o_m), 32'(e.em));
    chk({e.tag, "_lb2"}, 32'(o_l & e.lmask), 32'(e.el & e.lmask));
    @(posedge clk);
    if (!e.em[6]) exp_m++;
    if (!e.em[6] && exp_s != 15) exp_s++;
    if (!e.el[6]) exp_l++;
    #1;
    chk({e.tag, "_stall_main"}, 32'(stall_m), 32'(exp_m));
    chk({e.tag, "_stall_lb2"}, 32'(stall_l), 32'(exp_l));
    chk({e.tag, "_stall_sat"}, 32'(stall_s), 32'(exp_s));
  endtask

  task automatic async_reset(input string tag);
    #1 rst_n = 1'b0;
    idle();
    #1;
    chk({tag, "_out_main"}, 32'(o_m), 32'(DEF));
    chk({tag, "_out_lb2"}, 32'(o_l), 32'(DEF));
    chk({tag, "_stall_main"}, 32'(stall_m), 32'd0);
    chk({tag, "_stall_sat"}, 32'(stall_s), 32'd0);
    exp_m = 0; exp_l = 0; exp_s = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    #3;
    chk("reset_out_main", 32'(o_m), 32'(DEF));
    chk("reset_stall_main", 32'(stall_m), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1;

    idle();                                                        cyc("idle", DEF, DEF, ALL);

    // LOAD r3 in EX, ADD r1,r3 in ID
    drive(1'b1, OP_ADD, 3'd3, 3'd0, 1'b1, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0); cyc("lu_rs1", LU, LU, ALL);
    drive(1'b1, OP_ADD, 3'd5, 3'd6, 1'b1, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0); cyc("lu_after", DEF, LU, ALL);
    chk("lu_stall_is_1", 32'(stall_m), 32'd1);
    idle();                                                        cyc("lu_idle", DEF, DEF, ALL);

    // rs2 match but rs2 unused, then used; a redirect then cuts LOAD_STALL short
    drive(1'b1, OP_ADD, 3'd2, 3'd4, 1'b0, 1'b1, 1'b1, 3'd4, 1'b0, 1'b0); cyc("rs2_unused", DEF, DEF, ALL);
    drive(1'b1, OP_ADD, 3'd2, 3'd4, 1'b1, 1'b1, 1'b1, 3'd4, 1'b0, 1'b0); cyc("rs2_used", LU, LU, ALL);
    drive(1'b0, OP_ADD, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd7, 1'b1, 1'b0); cyc("ls_redirect", RD, RDM, RDM);
    idle();                                                        cyc("ls_exit", DEF, DEF, ALL);

    // Redirect and load-use in the same cycle
    drive(1'b1, OP_ADD, 3'd3, 3'd0, 1'b0, 1'b1, 1'b1, 3'd3, 1'b1, 1'b0); cyc("redir_lu", RD, RD, ALL);
    idle();                                                        cyc("redir_lu_next", DEF, DEF, ALL);

    // MUL occupies EX for three cycles; redirect and hazard ignored during the wait
    drive(1'b1, OP_MUL, 3'd1, 3'd2, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0); cyc("mul_issue", DEF, DEF, ALL);
    drive(1'b1, OP_ADD, 3'd2, 3'd0, 1'b0, 1'b1, 1'b1, 3'd2, 1'b1, 1'b0); cyc("mul_wait1", MW, MW, ALL);
    idle();                                                        cyc("mul_wait2", MW, MW, ALL);
    idle();                                                        cyc("mul_done", DEF, DEF, ALL);

    // Reset arrives in MUL_WAIT with cnt=1
    drive(1'b1, OP_MUL, 3'd1, 3'd2, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0); cyc("mul2_issue", DEF, DEF, ALL);
    idle();                                                        cyc("mul2_wait1", MW, MW, ALL);
    async_reset("rst_mul");

    // HALT, five halted cycles (one with a redirect), resume
    drive(1'b1, OP_HALT, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0); cyc("halt_issue", DEF, DEF, ALL);
    for (int i = 0; i < 5; i++) begin
      idle();
      ex_redirect = (i == 2);
      cyc("halted", HO, HO, ALL);
    end
    chk("halt_stall_is_5", 32'(stall_m), 32'd5);
    idle(); resume = 1'b1;                                         cyc("resume", RS, RS, ALL);
    idle();                                                        cyc("after_resume", DEF, DEF, ALL);
    idle(); resume = 1'b1;                                         cyc("resume_in_run", DEF, DEF, ALL);

    // Saturation of the 4-bit counter
    async_reset("rst_sat");
    drive(1'b1, OP_HALT, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0); cyc("sat_issue", DEF, DEF, ALL);
    for (int i = 0; i < 20; i++) begin
      idle();
      cyc("sat_halted", HO, HO, ALL);
    end
    chk("sat_is_15", 32'(stall_s), 32'd15);
    chk("main_is_20", 32'(stall_m), 32'd20);
    idle(); resume = 1'b1;                                         cyc("sat_resume", RS, RS, ALL);
    idle();                                                        cyc("sat_after", DEF, DEF, ALL);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
